// File: rtl/scsi_ctrl_pkg.sv
// rtl/scsi_ctrl_pkg.sv - state encoding and default timing constants for scsi_handshake_ctrl
package scsi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CAP,
        WAIT_HOST,
        WR_CAP,
        WR_SETTLE,
        ACK_ON,
        ACK_OFF
    } state_t;

    localparam int DEF_LE_PULSE    = 2;
    localparam int DEF_SETTLE      = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int CNT_W           = 3;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-stage synchroniser with asynchronous reset to a fixed level
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/scsi_handshake_ctrl.sv
// rtl/scsi_handshake_ctrl.sv - SCSI REQ/ACK handshake and data-latch LE sequencer
// Optional registered host interrupt enabled by SCSI_HANDSHAKE_IRQ_EN.
module scsi_handshake_ctrl
    import scsi_ctrl_pkg::*;
#(
    parameter int LE_PULSE    = DEF_LE_PULSE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SETTLE      = DEF_SETTLE
) (
    input  logic CLK,
    input  logic RST,
    input  logic HOST_WR_STB,
    input  logic HOST_RD_STB,
    input  logic IRQ_ENABLE,
    input  logic nREQ,
    input  logic nIO,
    input  logic nBSY,
    output logic RD_LE,
    output logic WR_LE,
    output logic WR_OE,
    output logic nACK,
    output logic STAT_REQ,
    output logic STAT_BUSY,
    output logic IRQ
);

    localparam logic [CNT_W-1:0] LE_LAST     = CNT_W'(LE_PULSE - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    logic nreq_s, nio_s, nbsy_s;
    logic req, io, bsy;

    // Synchronisers reset to the inactive (high) level so nothing looks asserted after reset.
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_req (
        .clk (CLK), .rst (RST), .d (nREQ), .q (nreq_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_io (
        .clk (CLK), .rst (RST), .d (nIO), .q (nio_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_bsy (
        .clk (CLK), .rst (RST), .d (nBSY), .q (nbsy_s)
    );

    assign req = ~nreq_s;
    assign io  = ~nio_s;
    assign bsy = ~nbsy_s;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             io_q, io_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            io_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            io_q  <= io_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        io_next    = io_q;
        RD_LE      = 1'b0;
        WR_LE      = 1'b0;
        WR_OE      = 1'b0;
        nACK       = 1'b1;
        case (state)
            IDLE: begin
                if (req) begin
                    io_next    = io;
                    state_next = io ? RD_CAP : WAIT_HOST;
                end
            end
            RD_CAP: begin
                RD_LE = 1'b1;
                if (cnt == LE_LAST) state_next = WAIT_HOST;
                else                cnt_next   = cnt + 1'b1;
            end
            WAIT_HOST: begin
                // Direction is the one frozen on IDLE exit; the other strobe is ignored.
                if (io_q && HOST_RD_STB)       state_next = ACK_ON;
                else if (!io_q && HOST_WR_STB) state_next = WR_CAP;
            end
            WR_CAP: begin
                WR_LE = 1'b1;
                if (cnt == LE_LAST) state_next = WR_SETTLE;
                else                cnt_next   = cnt + 1'b1;
            end
            WR_SETTLE: begin
                WR_OE = 1'b1;
                if (cnt == SETTLE_LAST) state_next = ACK_ON;
                else                    cnt_next   = cnt + 1'b1;
            end
            ACK_ON: begin
                nACK  = 1'b0;
                WR_OE = ~io_q;
                if (!req) state_next = ACK_OFF;
            end
            ACK_OFF: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state != IDLE && state != ACK_OFF && !bsy) begin
            state_next = ACK_OFF;
            cnt_next   = '0;
        end
    end

    assign STAT_REQ  = req;
    assign STAT_BUSY = (state != IDLE);

`ifdef SCSI_HANDSHAKE_IRQ_EN
    logic irq_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= IRQ_ENABLE && (state == WAIT_HOST);
        end
    end

    assign IRQ = irq_q;
`else
    logic unused_irq_enable;
    assign unused_irq_enable = IRQ_ENABLE;
    assign IRQ = 1'b0;
`endif

endmodule
